// File: rtl/reg_file_arbiter.sv
// reg_file_arbiter
//   Shares the single-write/X-port + Y-port register file between the CPU
//   control unit and a debug/monitor port. After reset it sweeps every
//   register to zero, then muxes the X/write port: the CPU wins by default,
//   but a debug request that has been denied STARVE_LIMIT consecutive cycles
//   is forced through and the CPU is stalled for that one cycle.
//
// Ports
//   CLK, RST                      clock, synchronous active-high reset
//   CPU_ADRX/ADRY/DIN/WR/ACTIVE   CPU side of the register file
//   CPU_STALL                     CPU must hold its instruction this cycle
//   DBG_REQ/WE/ADR/WDATA          debug request, held until DBG_GNT
//   DBG_GNT                       debug access performed this cycle
//   DBG_RDATA, DBG_VALID          read data / completion pulse, cycle after grant
//   RF_ADRX/ADRY/DIN/WR           to the register file
//   RF_DX                         register file async read of RF_ADRX
//   INIT_DONE                     sweep complete
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_INIT | zero sweep in progress, one register per cycle, CPU stalled
// S_RUN  | normal arbitration between CPU and debug port

module reg_file_arbiter #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 5,
    parameter int DEPTH        = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] CPU_ADRX,
    input  logic [ADDR_W-1:0] CPU_ADRY,
    input  logic [DATA_W-1:0] CPU_DIN,
    input  logic              CPU_WR,
    input  logic              CPU_ACTIVE,
    output logic              CPU_STALL,
    input  logic              DBG_REQ,
    input  logic              DBG_WE,
    input  logic [ADDR_W-1:0] DBG_ADR,
    input  logic [DATA_W-1:0] DBG_WDATA,
    output logic              DBG_GNT,
    output logic [DATA_W-1:0] DBG_RDATA,
    output logic              DBG_VALID,
    output logic [ADDR_W-1:0] RF_ADRX,
    output logic [ADDR_W-1:0] RF_ADRY,
    output logic [DATA_W-1:0] RF_DIN,
    output logic              RF_WR,
    input  logic [DATA_W-1:0] RF_DX,
    output logic              INIT_DONE
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [ADDR_W:0]   SWEEP_LAST = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W:0]     sweep_q;
    logic [ADDR_W:0]     sweep_d;
    logic [STARVE_W-1:0] starve_q;
    logic [STARVE_W-1:0] starve_d;
    logic                gnt;

    // Grant is blocked while RST is high so a forced write cannot land
    // in the same cycle the sweep is being restarted.
    assign gnt = (state_q == S_RUN) && !RST && DBG_REQ &&
                 (!CPU_ACTIVE || (starve_q == STARVE_MAX));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_INIT;
            sweep_q   <= '0;
            starve_q  <= '0;
            DBG_RDATA <= '0;
            DBG_VALID <= 1'b0;
        end else begin
            state_q   <= state_d;
            sweep_q   <= sweep_d;
            starve_q  <= starve_d;
            DBG_VALID <= gnt;
            if (gnt && !DBG_WE) begin
                DBG_RDATA <= RF_DX;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        sweep_d  = sweep_q;
        starve_d = '0;

        case (state_q)
            S_INIT: begin
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == SWEEP_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // A request still held after its grant counts as a new
                // request, so the count restarts from zero.
                if (DBG_REQ && !gnt) begin
                    if (CPU_ACTIVE && (starve_q != STARVE_MAX)) begin
                        starve_d = starve_q + 1'b1;
                    end else begin
                        starve_d = starve_q;
                    end
                end
            end
            default: begin
                state_d = S_INIT;
                sweep_d = '0;
            end
        endcase
    end

    always_comb begin
        RF_ADRX   = CPU_ADRX;
        RF_ADRY   = CPU_ADRY;
        RF_DIN    = CPU_DIN;
        RF_WR     = 1'b0;
        CPU_STALL = 1'b1;
        DBG_GNT   = gnt;
        INIT_DONE = 1'b0;

        if (!RST) begin
            case (state_q)
                S_INIT: begin
                    RF_ADRX = sweep_q[ADDR_W-1:0];
                    RF_DIN  = '0;
                    RF_WR   = 1'b1;
                end
                S_RUN: begin
                    INIT_DONE = 1'b1;
                    if (gnt) begin
                        RF_ADRX   = DBG_ADR;
                        RF_DIN    = DBG_WDATA;
                        RF_WR     = DBG_WE;
                        CPU_STALL = CPU_ACTIVE;
                    end else begin
                        RF_WR     = CPU_WR;
                        CPU_STALL = 1'b0;
                    end
                end
                default: begin
                    RF_WR = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_arbiter.sv
module tb_reg_file_arbiter;

    logic       CLK = 1'b0;
    logic       RST;
    logic [4:0] CPU_ADRX, CPU_ADRY, DBG_ADR, RF_ADRX, RF_ADRY;
    logic [7:0] CPU_DIN, DBG_WDATA, DBG_RDATA, RF_DIN, RF_DX;
    logic       CPU_WR, CPU_ACTIVE, CPU_STALL, DBG_REQ, DBG_WE, DBG_GNT;
    logic       DBG_VALID, RF_WR, INIT_DONE;

    int vec_cnt = 0;
    int miscmp  = 0;

    always #5 CLK = ~CLK;

    reg_file_arbiter dut (
        .CLK(CLK), .RST(RST),
        .CPU_ADRX(CPU_ADRX), .CPU_ADRY(CPU_ADRY), .CPU_DIN(CPU_DIN),
        .CPU_WR(CPU_WR), .CPU_ACTIVE(CPU_ACTIVE), .CPU_STALL(CPU_STALL),
        .DBG_REQ(DBG_REQ), .DBG_WE(DBG_WE), .DBG_ADR(DBG_ADR),
        .DBG_WDATA(DBG_WDATA), .DBG_GNT(DBG_GNT), .DBG_RDATA(DBG_RDATA),
        .DBG_VALID(DBG_VALID), .RF_ADRX(RF_ADRX), .RF_ADRY(RF_ADRY),
        .RF_DIN(RF_DIN), .RF_WR(RF_WR), .RF_DX(RF_DX), .INIT_DONE(INIT_DONE)
    );

    // Behavioural register file: write on rising edge, async X read.
    logic [7:0] rf_mem [32];
    always @(posedge CLK) if (RF_WR) rf_mem[RF_ADRX] <= RF_DIN;
    assign RF_DX = rf_mem[RF_ADRX];

    typedef struct {
        logic       ca;
        logic       cwr;
        logic [4:0] cadrx;
        logic [4:0] cadry;
        logic [7:0] cdin;
        logic       dreq;
        logic       dwe;
        logic [4:0] dadr;
        logic [7:0] dwd;
        logic       e_gnt;
        logic       e_stall;
        logic       e_wr;
        logic [4:0] e_adrx;
        logic [7:0] e_din;
        logic       e_valid;
        logic [7:0] e_rdata;
    } vec_t;

    vec_t tv [26];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ca, input logic cwr, input logic [4:0] cadrx,
                         input logic [4:0] cadry, input logic [7:0] cdin,
                         input logic dreq, input logic dwe, input logic [4:0] dadr,
                         input logic [7:0] dwd);
        CPU_ACTIVE = ca;  CPU_WR = cwr; CPU_ADRX = cadrx; CPU_ADRY = cadry;
        CPU_DIN = cdin;   DBG_REQ = dreq; DBG_WE = dwe; DBG_ADR = dadr;
        DBG_WDATA = dwd;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //            ca cwr adrx adry din   req we adr   wd    | gnt stl wr adrx din   vld rdata
        tv[0]  = '{0, 0, 5'h00, 5'h04, 8'h00, 0, 0, 5'h00, 8'h00, 0, 0, 0, 5'h00, 8'h00, 0, 8'h00};
        tv[1]  = '{0, 0, 5'h00, 5'h04, 8'h00, 1, 1, 5'h05, 8'hA5, 1, 0, 1, 5'h05, 8'hA5, 0, 8'h00};
        tv[2]  = '{0, 0, 5'h00, 5'h04, 8'h00, 1, 0, 5'h05, 8'h00, 1, 0, 0, 5'h05, 8'h00, 1, 8'h00};
        tv[3]  = '{1, 1, 5'h07, 5'h08, 8'h3C, 0, 0, 5'h00, 8'h00, 0, 0, 1, 5'h07, 8'h3C, 1, 8'hA5};
        tv[4]  = '{0, 0, 5'h02, 5'h08, 8'h11, 0, 0, 5'h00, 8'h00, 0, 0, 0, 5'h02, 8'h11, 0, 8'hA5};
        tv[5]  = '{1, 1, 5'h01, 5'h03, 8'h77, 1, 0, 5'h03, 8'h5A, 0, 0, 1, 5'h01, 8'h77, 0, 8'hA5};
        tv[6]  = tv[5];
        tv[7]  = tv[5];
        tv[8]  = tv[5];
        tv[9]  = '{1, 1, 5'h01, 5'h03, 8'h77, 1, 0, 5'h03, 8'h5A, 1, 1, 0, 5'h03, 8'h5A, 0, 8'hA5};
        tv[10] = '{1, 1, 5'h01, 5'h03, 8'h77, 1, 0, 5'h03, 8'h5A, 0, 0, 1, 5'h01, 8'h77, 1, 8'h00};
        tv[11] = '{1, 0, 5'h00, 5'h00, 8'h00, 0, 0, 5'h00, 8'h00, 0, 0, 0, 5'h00, 8'h00, 0, 8'h00};
        tv[12] = '{0, 0, 5'h00, 5'h00, 8'h00, 1, 0, 5'h07, 8'h00, 1, 0, 0, 5'h07, 8'h00, 0, 8'h00};
        tv[13] = '{0, 0, 5'h00, 5'h00, 8'h00, 1, 0, 5'h01, 8'h00, 1, 0, 0, 5'h01, 8'h00, 1, 8'h3C};
        tv[14] = '{0, 0, 5'h00, 5'h00, 8'h00, 0, 0, 5'h00, 8'h00, 0, 0, 0, 5'h00, 8'h00, 1, 8'h77};
        tv[15] = '{1, 0, 5'h02, 5'h06, 8'h12, 1, 1, 5'h1F, 8'hEE, 0, 0, 0, 5'h02, 8'h12, 0, 8'h77};
        tv[16] = tv[15];
        tv[17] = tv[15];
        tv[18] = '{1, 0, 5'h02, 5'h06, 8'h12, 0, 1, 5'h1F, 8'hEE, 0, 0, 0, 5'h02, 8'h12, 0, 8'h77};
        tv[19] = tv[15];
        tv[20] = tv[15];
        tv[21] = tv[15];
        tv[22] = tv[15];
        tv[23] = '{1, 0, 5'h02, 5'h06, 8'h12, 1, 1, 5'h1F, 8'hEE, 1, 1, 1, 5'h1F, 8'hEE, 0, 8'h77};
        tv[24] = '{0, 0, 5'h00, 5'h00, 8'h00, 1, 0, 5'h1F, 8'h00, 1, 0, 0, 5'h1F, 8'h00, 1, 8'h77};
        tv[25] = '{0, 0, 5'h00, 5'h00, 8'h00, 0, 0, 5'h00, 8'h00, 0, 0, 0, 5'h00, 8'h00, 1, 8'hEE};

        // Reset held, nothing requested
        RST = 1'b1;
        drive(0, 0, 5'h00, 5'h00, 8'h00, 0, 0, 5'h00, 8'h00);
        next_cycle();
        next_cycle();
        @(negedge CLK);
        chk("rst_rf_wr", 32'(RF_WR), 32'h0);
        chk("rst_stall", 32'(CPU_STALL), 32'h1);
        chk("rst_gnt", 32'(DBG_GNT), 32'h0);
        chk("rst_done", 32'(INIT_DONE), 32'h0);
        chk("rst_valid", 32'(DBG_VALID), 32'h0);
        chk("rst_rdata", 32'(DBG_RDATA), 32'h0);
        next_cycle();
        RST = 1'b0;

        // Zero sweep: one register per cycle, 32 cycles
        for (int i = 0; i < 32; i++) begin
            @(negedge CLK);
            chk("sweep_wr", 32'(RF_WR), 32'h1);
            chk("sweep_adrx", 32'(RF_ADRX), 32'(i));
            chk("sweep_din", 32'(RF_DIN), 32'h0);
            chk("sweep_stall", 32'(CPU_STALL), 32'h1);
            chk("sweep_done", 32'(INIT_DONE), 32'h0);
            next_cycle();
        end

        // Table-driven RUN vectors, one per cycle, starting cycle 33
        for (int k = 0; k < 26; k++) begin
            drive(tv[k].ca, tv[k].cwr, tv[k].cadrx, tv[k].cadry, tv[k].cdin,
                  tv[k].dreq, tv[k].dwe, tv[k].dadr, tv[k].dwd);
            @(negedge CLK);
            chk($sformatf("v%0d_done", k), 32'(INIT_DONE), 32'h1);
            chk($sformatf("v%0d_gnt", k), 32'(DBG_GNT), 32'(tv[k].e_gnt));
            chk($sformatf("v%0d_stall", k), 32'(CPU_STALL), 32'(tv[k].e_stall));
            chk($sformatf("v%0d_wr", k), 32'(RF_WR), 32'(tv[k].e_wr));
            chk($sformatf("v%0d_adrx", k), 32'(RF_ADRX), 32'(tv[k].e_adrx));
            chk($sformatf("v%0d_adry", k), 32'(RF_ADRY), 32'(tv[k].cadry));
            chk($sformatf("v%0d_din", k), 32'(RF_DIN), 32'(tv[k].e_din));
            chk($sformatf("v%0d_valid", k), 32'(DBG_VALID), 32'(tv[k].e_valid));
            chk($sformatf("v%0d_rdata", k), 32'(DBG_RDATA), 32'(tv[k].e_rdata));
            next_cycle();
        end

        // Reset arriving in a forced-grant write cycle
        drive(1, 0, 5'h00, 5'h00, 8'h00, 1, 1, 5'h09, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("starve_deny_gnt", 32'(DBG_GNT), 32'h0);
            next_cycle();
        end
        RST = 1'b1;
        @(negedge CLK);
        chk("rstgnt_rf_wr", 32'(RF_WR), 32'h0);
        chk("rstgnt_gnt", 32'(DBG_GNT), 32'h0);
        chk("rstgnt_stall", 32'(CPU_STALL), 32'h1);
        next_cycle();
        RST = 1'b0;

        // Debug read of 9 requested throughout the sweep, CPU idle
        drive(0, 0, 5'h00, 5'h00, 8'h00, 1, 0, 5'h09, 8'h00);
        for (int i = 0; i < 32; i++) begin
            @(negedge CLK);
            chk("init_req_gnt", 32'(DBG_GNT), 32'h0);
            chk("init_req_adrx", 32'(RF_ADRX), 32'(i));
            chk("init_req_valid", 32'(DBG_VALID), 32'h0);
            chk("init_req_done", 32'(INIT_DONE), 32'h0);
            next_cycle();
        end
        @(negedge CLK);
        chk("run1_gnt", 32'(DBG_GNT), 32'h1);
        chk("run1_adrx", 32'(RF_ADRX), 32'h09);
        chk("run1_wr", 32'(RF_WR), 32'h0);
        chk("run1_done", 32'(INIT_DONE), 32'h1);
        next_cycle();

        drive(0, 0, 5'h00, 5'h00, 8'h00, 1, 1, 5'h14, 8'h42);
        @(negedge CLK);
        chk("run2_valid", 32'(DBG_VALID), 32'h1);
        chk("run2_rdata", 32'(DBG_RDATA), 32'h00);
        chk("run2_wr", 32'(RF_WR), 32'h1);
        next_cycle();

        drive(0, 0, 5'h00, 5'h00, 8'h00, 1, 0, 5'h14, 8'h00);
        @(negedge CLK);
        chk("run3_valid", 32'(DBG_VALID), 32'h1);
        next_cycle();

        drive(0, 0, 5'h00, 5'h00, 8'h00, 1, 0, 5'h09, 8'h00);
        @(negedge CLK);
        chk("run4_rdata20", 32'(DBG_RDATA), 32'h42);
        next_cycle();

        drive(0, 0, 5'h00, 5'h00, 8'h00, 0, 0, 5'h00, 8'h00);
        @(negedge CLK);
        chk("reg9_cleared", 32'(DBG_RDATA), 32'h00);
        chk("run5_valid", 32'(DBG_VALID), 32'h1);
        next_cycle();
        @(negedge CLK);
        chk("run6_valid", 32'(DBG_VALID), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
